// File: rtl/simple_spi_master.sv
// SPI master: one WIDTH-bit full-duplex frame per start, MSB first, SCK idle at CPOL.
// Define SIMPLE_SPI_MASTER_CS_GUARD_EN to add a chip-select-high guard period after each frame.
module simple_spi_master #(
    parameter int unsigned WIDTH        = 40,
    parameter logic        CPOL         = 1'b1,
    parameter int unsigned CLKDIV       = 4,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value_mosi,
    output logic [WIDTH-1:0] value_miso,
    output logic             busy,
    output logic             done,
    output logic             pin_ncs,
    output logic             pin_clk,
    output logic             pin_mosi,
    input  logic             pin_miso
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD, SCK_LEAD, SCK_TRAIL, TRAIL, GUARD
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LEAD, SCK_LEAD, SCK_TRAIL, TRAIL
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] miso_q, miso_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ncs_q, ncs_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             div_last;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
    logic [GW-1:0]    gcnt_q, gcnt_d;
`endif

    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        miso_d  = miso_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ncs_d   = ncs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
        gcnt_d  = gcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEAD;
                    tx_d    = value_mosi;
                    rx_d    = '0;
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    ncs_d   = 1'b0;
                    sck_d   = CPOL;
                    mosi_d  = 1'b0;
                end
            end
            LEAD: begin
                if (div_last) begin
                    state_d = SCK_LEAD;
                    div_d   = '0;
                    sck_d   = ~CPOL;
                    mosi_d  = tx_q[WIDTH-1];
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SCK_LEAD: begin
                if (div_last) begin
                    state_d = SCK_TRAIL;
                    div_d   = '0;
                    sck_d   = CPOL;
                    rx_d    = {rx_q[WIDTH-2:0], pin_miso};
                    bit_d   = bit_q + BW'(1);
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SCK_TRAIL: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = SCK_LEAD;
                        tx_d    = {tx_q[WIDTH-2:0], 1'b0};
                        sck_d   = ~CPOL;
                        mosi_d  = tx_q[WIDTH-2];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            TRAIL: begin
                if (div_last) begin
                    div_d  = '0;
                    ncs_d  = 1'b1;
                    mosi_d = 1'b0;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
                    state_d = GUARD;
                    gcnt_d  = '0;
                    if (GUARD_CYCLES == 1) begin
                        done_d = 1'b1;
                        miso_d = rx_q;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    miso_d  = rx_q;
`endif
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
            GUARD: begin
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                    // done lands in the final guard cycle
                    if (gcnt_d == G_LAST) begin
                        done_d = 1'b1;
                        miso_d = rx_q;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            miso_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ncs_q   <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
            gcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    assign value_miso = miso_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pin_ncs    = ncs_q;
    assign pin_clk    = sck_q;
    assign pin_mosi   = mosi_q;

endmodule

// File: tb/tb_simple_spi_master.sv
// Directed bench for simple_spi_master: a 40-bit CLKDIV=2 instance with a
// bit-serial slave model, plus an 8-bit CLKDIV=1 instance for back-to-back frames.
module tb_simple_spi_master;

    localparam int unsigned G = 8;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
    localparam int GAP1 = 2 + G;
`else
    localparam int GAP1 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [39:0] vmosi0, vmiso0;
    logic [7:0]  vmosi1, vmiso1;
    logic        busy0, done0, ncs0, sck0, mosi0, miso0;
    logic        busy1, done1, ncs1, sck1, mosi1, miso1;

    int checks   = 0;
    int failures = 0;

    logic [39:0] sword;
    logic [39:0] cap0;
    int rises0 = 0;
    int base0  = 0;
    int k0;
    int lowcnt0  = 0;
    int donecnt0 = 0;
    int fallcnt0 = 0;
    int badmosi  = 0;
    logic ncs0_prev = 1'b1;

    always #5 clk = ~clk;

    simple_spi_master #(
        .WIDTH(40), .CPOL(1'b1), .CLKDIV(2), .GUARD_CYCLES(G)
    ) u_dut0 (
        .system_clk(clk), .reset(rst), .start(start0),
        .value_mosi(vmosi0), .value_miso(vmiso0),
        .busy(busy0), .done(done0), .pin_ncs(ncs0),
        .pin_clk(sck0), .pin_mosi(mosi0), .pin_miso(miso0)
    );

    simple_spi_master #(
        .WIDTH(8), .CPOL(1'b1), .CLKDIV(1), .GUARD_CYCLES(G)
    ) u_dut1 (
        .system_clk(clk), .reset(rst), .start(start1),
        .value_mosi(vmosi1), .value_miso(vmiso1),
        .busy(busy1), .done(done1), .pin_ncs(ncs1),
        .pin_clk(sck1), .pin_mosi(mosi1), .pin_miso(miso1)
    );

    // Slave: bit k of the frame (MSB first) is presented until the k-th SCK rise.
    always @(posedge sck0) rises0 <= rises0 + 1;
    always @(negedge ncs0) base0 <= rises0;
    always @(posedge sck0) cap0 <= {cap0[38:0], mosi0};

    always_comb begin
        k0 = rises0 - base0;
        miso0 = 1'b0;
        if (k0 >= 0 && k0 < 40) miso0 = sword[6'(39 - k0)];
    end

    always @(posedge clk) begin
        if (!ncs0) lowcnt0 <= lowcnt0 + 1;
        if (done0) donecnt0 <= donecnt0 + 1;
        if (ncs0_prev && !ncs0) fallcnt0 <= fallcnt0 + 1;
        ncs0_prev <= ncs0;
        if ((ncs0 && mosi0) || (ncs1 && mosi1)) badmosi <= badmosi + 1;
    end

    task automatic test_reset;
        rst = 1'b1;
        start0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ncs0 !== 1'b1) begin failures++; $display("FAIL rst_ncs got=%b exp=1", ncs0); end
        checks++;
        if (sck0 !== 1'b1) begin failures++; $display("FAIL rst_sck got=%b exp=1", sck0); end
        checks++;
        if (mosi0 !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi0); end
        checks++;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy0); end
        checks++;
        if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done0); end
        checks++;
        if (vmiso0 !== 40'h0) begin failures++; $display("FAIL rst_miso got=%h exp=0", vmiso0); end
        checks++;
        if (ncs1 !== 1'b1 || busy1 !== 1'b0) begin
            failures++; $display("FAIL rst_dut1 ncs=%b busy=%b exp 1/0", ncs1, busy1);
        end
        start0 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_start_ignored got=%b exp=0", busy0); end
    endtask

    task automatic test_frame;
        int low_s, dn_s;
        bit got;
        sword  = 40'h80_0000_0001;
        vmosi0 = 40'hA5_0F0F_1234;
        low_s = lowcnt0;
        dn_s  = donecnt0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        vmosi0 = 40'h00_FFFF_0000;
        checks++;
        if (busy0 !== 1'b1 || ncs0 !== 1'b0) begin
            failures++; $display("FAIL frame_accept busy=%b ncs=%b exp 1/0", busy0, ncs0);
        end
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done0) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL frame_done_timeout got=0 exp=1"); end
        checks++;
        if (vmiso0 !== 40'h80_0000_0001) begin
            failures++; $display("FAIL frame_miso got=%h exp=8000000001", vmiso0);
        end
        checks++;
        if (cap0 !== 40'hA5_0F0F_1234) begin
            failures++; $display("FAIL frame_mosi_bits got=%h exp=a50f0f1234", cap0);
        end
        checks++;
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
        if (ncs0 !== 1'b1 || busy0 !== 1'b1) begin
            failures++; $display("FAIL frame_done_state ncs=%b busy=%b exp 1/1", ncs0, busy0);
        end
`else
        if (ncs0 !== 1'b1 || busy0 !== 1'b0) begin
            failures++; $display("FAIL frame_done_state ncs=%b busy=%b exp 1/0", ncs0, busy0);
        end
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (lowcnt0 - low_s !== 164) begin
            failures++; $display("FAIL frame_ncs_low got=%0d exp=164", lowcnt0 - low_s);
        end
        checks++;
        if (donecnt0 - dn_s !== 1) begin
            failures++; $display("FAIL frame_done_count got=%0d exp=1", donecnt0 - dn_s);
        end
        checks++;
        if (done0 !== 1'b0 || vmiso0 !== 40'h80_0000_0001) begin
            failures++; $display("FAIL frame_hold done=%b miso=%h exp 0/8000000001", done0, vmiso0);
        end
    endtask

    task automatic test_rx_patterns;
        logic [39:0] pat [2];
        bit got;
        pat[0] = 40'hFF_FFFF_FFFF;
        pat[1] = 40'h00_0000_0000;
        for (int p = 0; p < 2; p++) begin
            sword  = pat[p];
            vmosi0 = 40'h3C_5A5A_C3C3;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            got = 1'b0;
            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                if (done0) begin got = 1'b1; break; end
            end
            checks++;
            if (!got || vmiso0 !== pat[p]) begin
                failures++; $display("FAIL rx_pattern%0d got=%h exp=%h", p, vmiso0, pat[p]);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start;
        int dn_s, fl_s;
        sword  = 40'h12_3456_789A;
        vmosi0 = 40'h0F_1E2D_3C4B;
        dn_s = donecnt0;
        fl_s = fallcnt0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (400) @(negedge clk);
        checks++;
        if (donecnt0 - dn_s !== 1) begin
            failures++; $display("FAIL ignore_done_count got=%0d exp=1", donecnt0 - dn_s);
        end
        checks++;
        if (fallcnt0 - fl_s !== 1) begin
            failures++; $display("FAIL ignore_frame_count got=%0d exp=1", fallcnt0 - fl_s);
        end
        checks++;
        if (vmiso0 !== 40'h12_3456_789A || busy0 !== 1'b0) begin
            failures++; $display("FAIL ignore_result miso=%h busy=%b exp 123456789a/0", vmiso0, busy0);
        end
    endtask

    task automatic test_reset_mid;
        int dn_s, r_s;
        bit got;
        sword  = 40'hFF_0000_FFFF;
        vmosi0 = 40'hAA_AAAA_AAAA;
        dn_s = donecnt0;
        r_s  = rises0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (rises0 - r_s == 17) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin failures++; $display("FAIL midrst_timeout got=0 exp=1"); end
        rst = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        checks++;
        if (ncs0 !== 1'b1 || sck0 !== 1'b1) begin
            failures++; $display("FAIL midrst_pins ncs=%b sck=%b exp 1/1", ncs0, sck0);
        end
        checks++;
        if (busy0 !== 1'b0 || vmiso0 !== 40'h0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_state busy=%b miso=%h done=%b exp 0/0/0", busy0, vmiso0, done0);
        end
        rst = 1'b0;
        start0 = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (donecnt0 !== dn_s || busy0 !== 1'b0) begin
            failures++; $display("FAIL midrst_no_done dones=%0d busy=%b exp 0/0", donecnt0 - dn_s, busy0);
        end
    endtask

    task automatic test_back_to_back;
        int f1, l1, f2;
        bit prev, rose, done_at_rise;
        f1 = -1; l1 = -1; f2 = -1;
        prev = 1'b1;
        rose = 1'b0;
        done_at_rise = 1'b0;
        vmosi1 = 8'hC3;
        start1 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev && !ncs1) begin
                if (f1 < 0) f1 = i;
                else if (rose) begin f2 = i; break; end
            end
            if (!prev && ncs1 && !rose) begin
                rose = 1'b1;
                l1 = i - 1;
                done_at_rise = done1;
            end
            prev = ncs1;
        end
        start1 = 1'b0;
        checks++;
        if (f1 < 0 || f2 < 0) begin failures++; $display("FAIL b2b_timeout f1=%0d f2=%0d", f1, f2); end
        checks++;
        if (l1 - f1 + 1 !== 18) begin failures++; $display("FAIL b2b_low_len got=%0d exp=18", l1 - f1 + 1); end
        checks++;
        if (f2 - l1 !== GAP1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", f2 - l1, GAP1); end
`ifndef SIMPLE_SPI_MASTER_CS_GUARD_EN
        checks++;
        if (done_at_rise !== 1'b1) begin failures++; $display("FAIL b2b_done_at_rise got=%b exp=1", done_at_rise); end
`endif
        checks++;
        if (vmiso1 !== 8'hFF) begin failures++; $display("FAIL b2b_miso got=%h exp=ff", vmiso1); end
        repeat (40) @(negedge clk);
    endtask

`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
    task automatic test_guard;
        int fl_s, l, d;
        bit prev, got;
        sword  = 40'h55_5555_5555;
        vmosi0 = 40'h01_0203_0405;
        fl_s = fallcnt0;
        l = -1; d = -1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        prev = ncs0;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (!prev && ncs0) begin l = i - 1; start0 = 1'b1; end
            if (done0) begin d = i; got = 1'b1; break; end
            prev = ncs0;
        end
        checks++;
        if (!got || d - l !== G) begin failures++; $display("FAIL guard_done_delay got=%0d exp=%0d", d - l, G); end
        checks++;
        if (busy0 !== 1'b1) begin failures++; $display("FAIL guard_busy_at_done got=%b exp=1", busy0); end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL guard_busy_drop got=%b exp=0", busy0); end
        repeat (200) @(negedge clk);
        checks++;
        if (fallcnt0 - fl_s !== 1) begin failures++; $display("FAIL guard_start_ignored frames=%0d exp=1", fallcnt0 - fl_s); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        vmosi0 = '0;
        vmosi1 = '0;
        miso1 = 1'b1;
        sword = '0;
        test_reset();
        test_frame();
        test_rx_patterns();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SIMPLE_SPI_MASTER_CS_GUARD_EN
        test_guard();
`endif
        checks++;
        if (badmosi !== 0) begin failures++; $display("FAIL mosi_idle_zero got=%0d exp=0", badmosi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_spi_master.md
SIMPLE_SPI_MASTER -- requirements
Module: simple_spi_master

Interface
REQ-001 Parameter WIDTH, default 40, meaning frame length in bits (matches the FPGA SPI slave frame).
REQ-002 Parameter CPOL, default 1'b1, meaning the idle level of pin_clk.
REQ-003 Parameter CLKDIV, default 4, meaning pin_clk half-period in system_clk cycles (legal range >= 1).
REQ-004 Parameter GUARD_CYCLES, default 8, meaning the post-frame chip-select guard length in cycles (used only with the guard macro).
REQ-005 Port: system_clk, input, 1, the single clock; every register SHALL update on its rising edge.
REQ-006 Port: reset, input, 1, the synchronous active-high reset.
REQ-007 Port: start, input, 1, the frame request, sampled only while busy=0.
REQ-008 Port: value_mosi, input, WIDTH, the word to transmit, MSB first.
REQ-009 Port: value_miso, output, WIDTH, the last complete received word.
REQ-010 Port: busy, output, 1, high from the cycle after start is accepted until the frame completes.
REQ-011 Port: done, output, 1, a one-cycle pulse marking that value_miso has been updated.
REQ-012 Port: pin_ncs, output, 1, the active-low chip select.
REQ-013 Port: pin_clk, output, 1, SCK.
REQ-014 Port: pin_mosi, output, 1, serial data out.
REQ-015 Port: pin_miso, input, 1, serial data in.

Function
REQ-016 The block SHALL have the FSM states IDLE, LEAD, SCK_LEAD, SCK_TRAIL, TRAIL and GUARD; GUARD exists only with the guard macro.
REQ-017 In IDLE with start=1 at cycle T, the block SHALL, at T+1, capture value_mosi into the shift register, set busy=1 and pin_ncs=0, and enter LEAD.
REQ-018 LEAD SHALL last CLKDIV cycles with pin_clk=CPOL, then enter SCK_LEAD.
REQ-019 On entry to SCK_LEAD, pin_clk SHALL go to ~CPOL and pin_mosi SHALL present the current MSB; the state SHALL hold CLKDIV cycles.
REQ-020 On entry to SCK_TRAIL, pin_clk SHALL return to CPOL and pin_miso SHALL be shifted into the receive-register LSB; the state SHALL hold CLKDIV cycles.
REQ-021 After the WIDTH-th SCK_TRAIL the FSM SHALL enter TRAIL; otherwise it SHALL shift the transmit register left and return to SCK_LEAD.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL count exactly WIDTH edge pairs, with no wrap.
REQ-023 TRAIL SHALL last CLKDIV cycles, then pin_ncs SHALL return to 1.
REQ-024 pin_ncs SHALL stay low for exactly CLKDIV*(2*WIDTH+2) cycles per frame.
REQ-025 value_miso SHALL be loaded from the receive register only in the cycle done=1, and SHALL hold its value otherwise.
REQ-026 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-027 start held high continuously SHALL produce back-to-back frames, each accepted the first cycle busy=0.
REQ-028 pin_mosi SHALL be 0 whenever pin_ncs=1.
REQ-029 Changes to value_mosi after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-030 reset=1 SHALL force, on the next edge: FSM=IDLE, pin_ncs=1, pin_clk=CPOL, pin_mosi=0, busy=0, done=0, value_miso=0 and all counters=0.
REQ-031 A reset mid-frame SHALL abort the frame with no done pulse; start SHALL be ignored while reset=1.

Configuration
REQ-032 With SIMPLE_SPI_MASTER_CS_GUARD_EN defined, TRAIL SHALL be followed by GUARD, which holds pin_ncs=1 and busy=1 for GUARD_CYCLES cycles; done SHALL pulse in the last GUARD cycle and busy SHALL drop the next cycle.
REQ-033 Without the macro, done SHALL pulse in the cycle pin_ncs returns to 1, busy SHALL drop in that same cycle, and no guard logic SHALL exist.

Verification
REQ-034 Scenario: WIDTH=40, CLKDIV=2, value_mosi=40'hA5_0F0F_1234, slave returns 40'h80_0000_0001 -> pin_mosi bit sequence equals A50F0F1234 MSB first, value_miso=40'h8000000001 at done, and pin_ncs low for exactly 164 cycles.
REQ-035 Scenario: start pulsed 10 cycles after acceptance -> exactly one frame occurs and exactly one done pulse.
REQ-036 Scenario: reset asserted when the bit counter reads 17 -> the next cycle shows pin_ncs=1, pin_clk=1, busy=0 and value_miso=0, with no done pulse.
REQ-037 Scenario: CLKDIV=1, start held high -> two consecutive frames, with the second pin_ncs fall exactly 2 cycles after the first rise (no macro).
REQ-038 Scenario: macro defined, GUARD_CYCLES=8 -> done occurs 8 cycles after pin_ncs rises, and a start issued during guard is ignored.
REQ-039 Scenario: pin_miso tied to 1, then tied to 0 -> value_miso reads 40'hFF_FFFF_FFFF, then 0.
